// File: rtl/timer_pkg.sv
// Shared constants and width helpers for the timer counting core.
package timer_pkg;

    localparam logic MODE_UP     = 1'b0;
    localparam logic MODE_UPDOWN = 1'b1;
    localparam logic CLK_SEL_INT = 1'b0;
    localparam logic CLK_SEL_EXT = 1'b1;
    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;

    function automatic int presc_width(input int cw);
        return cw - 5;
    endfunction

    // Divider must reach 2^(2^pw - 1) - 1, so it needs 2^pw - 1 bits.
    function automatic int div_width(input int cw);
        return (1 << (cw - 5)) - 1;
    endfunction

endpackage

// File: rtl/timer_tick_gen.sv
// Tick source selection, ext_clk synchronizer/edge detect and
// power-of-two prescaler producing the count step strobe.
module timer_tick_gen
    import timer_pkg::*;
#(
    parameter int COUNTER_BIT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic                         i_clock_selector,
    input  logic                         i_ext_clk,
    input  logic [COUNTER_BIT_WIDTH-6:0] i_prescaler,
    output logic                         o_step
);

    localparam int DW = div_width(COUNTER_BIT_WIDTH);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_sync3;
    logic [DW-1:0] r_div;
    logic [DW-1:0] w_term;
    logic          w_tick;
    logic          w_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_ext_clk;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    always_comb begin
        w_term = '0;
        for (int i = 0; i < DW; i++) begin
            w_term[i] = (i < int'(i_prescaler));
        end
    end

    assign w_tick = (i_clock_selector == CLK_SEL_EXT) ?
                    (r_sync2 & ~r_sync3) : 1'b1;
    // >= so a shrunk prescaler steps on the very next tick.
    assign w_hit  = (r_div >= w_term);
    assign o_step = i_start & w_tick & w_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if (!i_start) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= w_hit ? '0 : r_div + DW'(1);
        end
    end

endmodule

// File: rtl/timer_counter.sv
// Timer count/direction/compare core. Define TIMER_OVF_EN to add
// the ovf wrap/turnaround pulse output.
module timer_counter
    import timer_pkg::*;
#(
    parameter int COUNTER_BIT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         clock_selector,
    input  logic                         count_mode,
    input  logic [COUNTER_BIT_WIDTH-6:0] prescaler,
    input  logic                         ext_clk,
    input  logic [COUNTER_BIT_WIDTH-1:0] count_min,
    input  logic [COUNTER_BIT_WIDTH-1:0] count_max,
    input  logic [COUNTER_BIT_WIDTH-1:0] cmp_0_value,
    input  logic [COUNTER_BIT_WIDTH-1:0] cmp_1_value,
`ifdef TIMER_OVF_EN
    output logic                         ovf,
`endif
    output logic [COUNTER_BIT_WIDTH-1:0] count,
    output logic                         cmp_0_f,
    output logic                         cmp_1_f
);

    localparam int CW = COUNTER_BIT_WIDTH;

    logic [CW-1:0] r_count;
    logic          r_dir;
    logic          r_cmp0;
    logic          r_cmp1;
    logic [CW-1:0] w_next;
    logic          w_dir_n;
    logic          w_step;

    timer_tick_gen #(
        .COUNTER_BIT_WIDTH(CW)
    ) u_tick (
        .clk             (clk),
        .rst             (rst),
        .i_start         (start),
        .i_clock_selector(clock_selector),
        .i_ext_clk       (ext_clk),
        .i_prescaler     (prescaler),
        .o_step          (w_step)
    );

    always_comb begin
        w_next  = r_count;
        w_dir_n = r_dir;
        if (count_min >= count_max) begin
            w_next  = count_min;
            w_dir_n = DIR_UP;
        end else if (count_mode == MODE_UP) begin
            w_dir_n = DIR_UP;
            w_next  = (r_count >= count_max) ? count_min : r_count + CW'(1);
        end else if (r_dir == DIR_UP) begin
            if (r_count >= count_max) begin
                w_dir_n = DIR_DOWN;
                w_next  = count_max - CW'(1);
            end else begin
                w_next  = r_count + CW'(1);
            end
        end else begin
            if (r_count <= count_min) begin
                w_dir_n = DIR_UP;
                w_next  = count_min + CW'(1);
            end else begin
                w_next  = r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_dir   <= DIR_UP;
            r_cmp0  <= 1'b0;
            r_cmp1  <= 1'b0;
        end else if (w_step) begin
            r_count <= w_next;
            r_dir   <= w_dir_n;
            r_cmp0  <= (w_next == cmp_0_value);
            r_cmp1  <= (w_next == cmp_1_value);
        end else begin
            r_cmp0  <= 1'b0;
            r_cmp1  <= 1'b0;
        end
    end

    assign count   = r_count;
    assign cmp_0_f = r_cmp0;
    assign cmp_1_f = r_cmp1;

`ifdef TIMER_OVF_EN
    logic w_wrap;
    logic r_ovf;

    assign w_wrap = (count_min >= count_max) ||
                    ((count_mode == MODE_UP) && (r_count >= count_max)) ||
                    ((count_mode == MODE_UPDOWN) && (r_dir == DIR_DOWN) &&
                     (r_count <= count_min));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_step & w_wrap;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_timer_counter.sv
// Directed + randomized bench for timer_counter against a
// behavioural model of the counting rules.
module tb_timer_counter;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          clock_selector = 1'b0;
    logic          count_mode = 1'b0;
    logic          ext_clk = 1'b0;
    logic [CW-6:0] prescaler = '0;
    logic [CW-1:0] count_min = '0;
    logic [CW-1:0] count_max = '0;
    logic [CW-1:0] cmp_0_value = '0;
    logic [CW-1:0] cmp_1_value = '0;
    logic [CW-1:0] count;
    logic          cmp_0_f;
    logic          cmp_1_f;
`ifdef TIMER_OVF_EN
    logic          ovf;
`endif

    timer_counter #(
        .COUNTER_BIT_WIDTH(CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .clock_selector(clock_selector),
        .count_mode    (count_mode),
        .prescaler     (prescaler),
        .ext_clk       (ext_clk),
        .count_min     (count_min),
        .count_max     (count_max),
        .cmp_0_value   (cmp_0_value),
        .cmp_1_value   (cmp_1_value),
`ifdef TIMER_OVF_EN
        .ovf           (ovf),
`endif
        .count         (count),
        .cmp_0_f       (cmp_0_f),
        .cmp_1_f       (cmp_1_f)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: count, direction (0 up / 1 down), divider,
    // pulse flags and ext_clk samples from the last three edges.
    int m_cnt = 0;
    int m_dir = 0;
    int m_div = 0;
    bit m_c0 = 0;
    bit m_c1 = 0;
    bit m_ovf = 0;
    bit h[3] = '{0, 0, 0};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_dir = 0; m_div = 0;
        m_c0 = 0; m_c1 = 0; m_ovf = 0;
        h[0] = 0; h[1] = 0; h[2] = 0;
    endtask

    task automatic advance();
        int mn;
        int mx;
        mn = int'(count_min);
        mx = int'(count_max);
        m_ovf = 0;
        if (mn >= mx) begin
            m_cnt = mn; m_dir = 0; m_ovf = 1;
        end else if (count_mode == 1'b0) begin
            m_dir = 0;
            if (m_cnt >= mx) begin
                m_cnt = mn; m_ovf = 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else if (m_dir == 0) begin
            if (m_cnt >= mx) begin
                m_dir = 1; m_cnt = mx - 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else begin
            if (m_cnt <= mn) begin
                m_dir = 0; m_cnt = mn + 1; m_ovf = 1;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
        m_c0 = (m_cnt == int'(cmp_0_value));
        m_c1 = (m_cnt == int'(cmp_1_value));
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(m_cnt));
        chk({tag, ".cmp0"}, 32'(cmp_0_f), 32'(m_c0));
        chk({tag, ".cmp1"}, 32'(cmp_1_f), 32'(m_c1));
`ifdef TIMER_OVF_EN
        chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
`endif
    endtask

    task automatic cyc(input string tag);
        bit tk;
        int term;
        @(posedge clk);
        if (rst) begin
            tk = clock_selector ? (h[1] && !h[2]) : 1'b1;
            h[2] = h[1]; h[1] = h[0]; h[0] = ext_clk;
            m_c0 = 0; m_c1 = 0; m_ovf = 0;
            term = (1 << int'(prescaler)) - 1;
            if (!start) begin
                m_div = 0;
            end else if (tk) begin
                if (m_div >= term) begin
                    m_div = 0;
                    advance();
                end else begin
                    m_div = m_div + 1;
                end
            end
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic cfg(input bit mode, input int mn, input int mx,
                       input int c0, input int c1, input int p);
        count_mode  = mode;
        count_min   = CW'(mn);
        count_max   = CW'(mx);
        cmp_0_value = CW'(c0);
        cmp_1_value = CW'(c1);
        prescaler   = (CW-5)'(p);
    endtask

    initial begin
        int wrap_seq [8] = '{1, 2, 3, 4, 5, 2, 3, 4};
        int guard;

        #1;
        chk("reset.count", 32'(count), 32'd0);
        chk("reset.cmp0", 32'(cmp_0_f), 32'd0);
        chk("reset.cmp1", 32'(cmp_1_f), 32'd0);

        @(negedge clk);
        cfg(1'b0, 2, 5, 3, 5, 0);
        rst = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc("wrap");
            chk("wrap.seq", 32'(count), 32'(wrap_seq[i]));
        end
        for (int i = 0; i < 12; i++) cyc("wrap");

        cfg(1'b1, 1, 4, 3, 1, 0);
        for (int i = 0; i < 24; i++) cyc("tri");

        cfg(1'b0, 0, 100, 5, 7, 3);
        for (int i = 0; i < 43; i++) cyc("presc");
        start = 1'b0;
        for (int i = 0; i < 10; i++) cyc("hold");
        start = 1'b1;
        for (int i = 0; i < 30; i++) cyc("resume");
        prescaler = '0;
        for (int i = 0; i < 4; i++) cyc("presc_shrink");

        clock_selector = 1'b1;
        cfg(1'b0, 0, 200, 10, 12, 0);
        for (int i = 0; i < 60; i++) begin
            if (i % 5 == 0) ext_clk = ~ext_clk;
            cyc("ext");
        end
        for (int i = 0; i < 30; i++) cyc("ext_static");
        clock_selector = 1'b0;

        cfg(1'b0, 7, 7, 7, 7, 0);
        for (int i = 0; i < 6; i++) cyc("degen");
        chk("degen.hold7", 32'(count), 32'd7);
        cmp_0_value = 8'd9;
        for (int i = 0; i < 4; i++) cyc("degen_nocmp");

        cfg(1'b0, 0, 20, 4, 4, 0);
        for (int i = 0; i < 8; i++) cyc("both_cmp");
        start = 1'b0;
        cmp_0_value = count;
        for (int i = 0; i < 4; i++) cyc("stop_eq");
        start = 1'b1;

        for (int k = 0; k < 40; k++) begin
            count_mode     = 1'($urandom % 2);
            count_min      = CW'($urandom_range(0, 10));
            count_max      = CW'($urandom_range(0, 14));
            cmp_0_value    = CW'($urandom_range(0, 14));
            cmp_1_value    = ($urandom % 3 == 0) ? cmp_0_value :
                             CW'($urandom_range(0, 14));
            prescaler      = (CW-5)'($urandom_range(0, 2));
            clock_selector = ($urandom % 4 == 0);
            start          = ($urandom % 5 != 0);
            for (int i = 0; i < 12; i++) begin
                if ($urandom % 3 == 0) ext_clk = ~ext_clk;
                cyc("rand");
            end
        end

        clock_selector = 1'b0;
        start = 1'b1;
        cfg(1'b0, 0, 20, 30, 31, 0);
        guard = 0;
        while (m_cnt != 9 && guard < 60) begin
            cyc("to9");
            guard++;
        end
        chk("reach9", 32'(count), 32'd9);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_async.count", 32'(count), 32'd0);
        chk("rst_async.cmp0", 32'(cmp_0_f), 32'd0);
        chk("rst_async.cmp1", 32'(cmp_1_f), 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc("post_rst_idle");
        start = 1'b1;
        for (int i = 0; i < 5; i++) cyc("post_rst_run");
        chk("post_rst.count", 32'(count), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Counting core that sits directly downstream of the timer register file.
- Consumes the control fields (start, count_mode, clock_selector, prescaler), the count bounds and the two compare values.
- Produces the live count and the single-cycle compare-match pulses that the register file accumulates into its sticky status flags.
- Tick source is either the system clock or a synchronized external clock, divided by a power-of-two prescaler.

Parameters:
- COUNTER_BIT_WIDTH, 8, width of count, bounds and compare values; prescaler field width is COUNTER_BIT_WIDTH-5.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  1 = run, 0 = hold count and clear prescaler.
- clock_selector  in  1  0 = tick every clk; 1 = tick on synchronized rising edge of ext_clk.
- count_mode  in  1  0 = up with wrap; 1 = up/down (triangle).
- prescaler  in  COUNTER_BIT_WIDTH-5  tick divisor exponent; divisor = 2^prescaler.
- ext_clk  in  1  asynchronous external tick source.
- count_min  in  COUNTER_BIT_WIDTH  lower count bound.
- count_max  in  COUNTER_BIT_WIDTH  upper count bound.
- cmp_0_value  in  COUNTER_BIT_WIDTH  compare 0 value.
- cmp_1_value  in  COUNTER_BIT_WIDTH  compare 1 value.
- count  out  COUNTER_BIT_WIDTH  current count (registered).
- cmp_0_f  out  1  one-clk pulse on compare-0 match.
- cmp_1_f  out  1  one-clk pulse on compare-1 match.

Behaviour:
- Reset values:
  - count = 0, dir = up, cmp_0_f = cmp_1_f = 0.
  - Prescaler counter = 0, synchronizer and edge flops = 0.
- Tick generation:
  - clock_selector=0: tick every clk.
  - clock_selector=1: ext_clk passes a 2-flop synchronizer plus an edge-detect flop. Tick is one clk wide, 3 clk after the ext_clk rising edge.
  - The synchronizer always runs, independent of start.
- Prescaler:
  - Counter width is 2^(COUNTER_BIT_WIDTH-5)-1 bits.
  - On each tick: if the counter equals 2^prescaler-1, issue a step and clear the counter; else increment.
  - prescaler=0 gives one step per tick.
  - A change to prescaler takes effect immediately. If the counter already exceeds the new terminal value, the next tick steps and clears it.
- start=0: no steps, prescaler counter held at 0, count holds its value, dir holds its value.
- start 1 after 0: counting resumes from the held count. No reload.
- Step, mode 0 (up):
  - count >= count_max -> count_min.
  - Otherwise -> count+1.
  - dir is forced to up.
- Step, mode 1 (up/down):
  - dir up and count >= count_max: dir <= down, count <= count_max-1.
  - dir down and count <= count_min: dir <= up, count <= count_min+1.
  - Otherwise count moves one in the direction of dir.
- Degenerate bounds (count_min >= count_max), either mode: each step loads count_min, dir <= up.
- Count outside [count_min, count_max] after a bounds change: the rules above apply unmodified, so it snaps to count_min (mode 0) or turns around.
- Compare:
  - cmp_x_f is registered. It is 1 for exactly the one clk in which count first presents a stepped-to value equal to cmp_x_value.
  - No pulse while held or stopped, even if count equals the compare value.
  - Both flags may pulse in the same cycle.
- Asynchronous reset mid-count: immediate return to the reset values. Counting restarts from 0 only once start=1.

Optional Feature:
- TIMER_OVF_EN defined:
  - Adds output port ovf (1 bit, reset 0). It is a one-clk registered pulse aligned with count.
  - It fires on a mode-0 wrap (max->min), a mode-1 turnaround at count_min, and every step under degenerate bounds.
- TIMER_OVF_EN undefined: port and its logic are absent.

Decomposition:
- timer_pkg holds:
  - Constants: MODE_UP=0, MODE_UPDOWN=1, CLK_SEL_INT=0, CLK_SEL_EXT=1, DIR_UP=0, DIR_DOWN=1.
  - A function that derives the prescaler width from COUNTER_BIT_WIDTH.
- One sub-module, timer_tick_gen: synchronizer, edge detect, tick mux and prescaler, producing step. timer_counter instantiates it and holds the count, direction and compare logic.

Test Plan:
- Mode 0 wrap: min=2, max=5, prescaler=0, int clk, start=1 -> count 0,1,2,3,4,5,2,3...
  - With TIMER_OVF_EN: ovf pulses on each 5->2.
- Mode 1 triangle: min=1, max=4 -> count 1,2,3,4,3,2,1,2... cmp_0=3 -> cmp_0_f pulses on every visit to 3, both directions.
- Prescaler: prescaler=3, int clk -> count increments exactly once per 8 clk. start=0 mid-run holds count and clears the divider. Resume -> first step 8 clk later.
- External clock: clock_selector=1, ext_clk period 10 clk -> one step per ext rising edge, count update 3 clk after the edge. No steps while ext_clk is static.
- Boundaries:
  - min=max=7 -> count=7 after the first step and stays there, with no cmp pulse repeat unless a step lands on cmp.
  - cmp_0=cmp_1=count target -> both flags pulse in the same cycle.
- Reset: assert rst low mid-count with count=9 -> count=0, flags 0 immediately, without waiting for clk.
